// File: rtl/divider_seq_pkg.sv
// -----------------------------------------------------------------------------
// divider_seq_pkg
//   Shared definitions for the sequential divider: state encoding, the
//   default datapath width, and the fixed results returned for the two
//   operand combinations that skip the iteration loop.
//   No ports; imported by divider_seq and divider_seq_div_step.
// -----------------------------------------------------------------------------
package divider_seq_pkg;

    // Default datapath width; it is also the number of CALC iterations.
    localparam int DIV_WIDTH = 32;

    // FSM state encoding (legacy-compatible plain constants).
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Quotient returned when dividing by zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = {DIV_WIDTH{1'b1}};

    // Most negative two's-complement value; MIN / -1 overflows.
    localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage : divider_seq_pkg

// File: rtl/divider_seq_div_step.sv
// -----------------------------------------------------------------------------
// divider_seq_div_step
//   One radix-2 restoring-division step, purely combinational.
//   The partial remainder is shifted left with the next dividend bit, and
//   the divisor is trial-subtracted over WIDTH+1 bits. The subtraction is a
//   carry-lookahead adder (a + ~b + 1) built in 4-bit lookahead groups; its
//   carry-out is 1 exactly when the difference is non-negative.
//
//   Ports:
//     rem_in    [WIDTH-1:0]  partial remainder (always < divisor)
//     dvd_bit                next dividend bit shifted in at the LSB
//     divisor   [WIDTH-1:0]  magnitude of the divisor (non-zero)
//     rem_next  [WIDTH-1:0]  partial remainder after this step
//     q_bit                  quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_seq_div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    localparam int N  = WIDTH + 1;      // trial-subtraction width
    localparam int GS = 4;              // lookahead group size
    localparam int NG = (N + GS - 1) / GS;

    logic [N-1:0] a;       // shifted partial remainder
    logic [N-1:0] b;       // inverted, zero-extended divisor
    logic [N-1:0] g;       // bit generate
    logic [N-1:0] p;       // bit propagate
    logic [N:0]   c;       // carry into each bit, c[N] = carry-out
    logic [WIDTH-1:0] diff_lo;

    assign a = {rem_in, dvd_bit};
    assign b = ~{1'b0, divisor};
    assign g = a & b;
    assign p = a ^ b;

    // Within a group each carry is a flat sum-of-products of the group's
    // generate/propagate terms and the group carry-in; groups are chained.
    always_comb begin
        logic cin_grp;
        logic gen;
        logic prop;
        int   hi;
        c       = '0;
        c[0]    = 1'b1;            // +1 completes the two's-complement negate
        cin_grp = 1'b1;
        gen     = 1'b0;
        prop    = 1'b1;
        hi      = 0;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GS; j++) begin
                if (k * GS + j < N) begin
                    gen  = 1'b0;
                    prop = 1'b1;
                    for (int m = k * GS + j; m >= k * GS; m--) begin
                        gen  = gen | (prop & g[m]);
                        prop = prop & p[m];
                    end
                    c[k * GS + j + 1] = gen | (prop & cin_grp);
                end
            end
            hi      = ((k + 1) * GS < N) ? (k + 1) * GS : N;
            cin_grp = c[hi];
        end
    end

    // The kept difference is always below the divisor, so its top bit is
    // zero and only the low WIDTH bits need a sum.
    assign diff_lo  = p[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign q_bit    = c[N];
    // On restore the shifted value is below the divisor, so a[WIDTH] is 0.
    assign rem_next = q_bit ? diff_lo : a[WIDTH-1:0];

endmodule : divider_seq_div_step

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
//   Iterative radix-2 restoring divider, one quotient bit per cycle.
//   Signed operation divides magnitudes and fixes signs in one extra cycle
//   (truncating division: remainder takes the sign of the dividend).
//   Divide-by-zero and signed MIN/-1 are resolved at accept time.
//
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     in_valid / in_ready    operand handshake (ready only in IDLE)
//     x, y                   dividend, divisor
//     is_signed              1 = two's-complement operands
//     out_valid / out_ready  result handshake (valid only in DONE)
//     quotient, remainder    registered results, stable while out_valid
//     div_by_zero            set with a y==0 result, qualified by out_valid
// -----------------------------------------------------------------------------
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem;     // partial remainder
    logic [WIDTH-1:0] dvd;      // dividend bits out the top, quotient bits in
    logic [WIDTH-1:0] dsr;      // divisor magnitude
    logic             q_neg;
    logic             r_neg;

    // Operand sign decode and magnitudes, used only on accept.
    logic             sx;
    logic             sy;
    logic [WIDTH-1:0] ax;
    logic [WIDTH-1:0] ay;
    logic             ovf;

    assign sx  = is_signed & x[WIDTH-1];
    assign sy  = is_signed & y[WIDTH-1];
    assign ax  = sx ? -x : x;
    assign ay  = sy ? -y : y;
    assign ovf = is_signed && (x == MIN_NEG) && (y == ALL_ONES);

    // Single restoring step on the current registers.
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    divider_seq_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in   (prem),
        .dvd_bit  (dvd[WIDTH-1]),
        .divisor  (dsr),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Handshake outputs decode registered state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            prem        <= '0;
            dvd         <= '0;
            dsr         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd   <= ax;
                        dsr   <= ay;
                        q_neg <= sx ^ sy;
                        r_neg <= sx;
                        if (y == '0) begin
                            quotient    <= ALL_ONES;
                            remainder   <= x;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else if (ovf) begin
                            // MIN / -1 wraps back to MIN with no remainder.
                            quotient  <= MIN_NEG;
                            remainder <= '0;
                            state     <= DONE;
                        end else begin
                            prem  <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem <= step_rem;
                    dvd  <= {dvd[WIDTH-2:0], step_q};
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= q_neg ? -dvd  : dvd;
                    remainder <= r_neg ? -prem : prem;
                    state     <= DONE;
                end
                DONE: begin
                    // Return to IDLE only; a new accept needs a fresh cycle.
                    if (out_ready) begin
                        div_by_zero <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : divider_seq

// File: tb/tb_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_seq
//   Directed bench for divider_seq. Expected results come from a plain
//   arithmetic model (64-bit integer division); the table also carries
//   hand-computed literals that pin the model. A monitor checks every
//   out_valid cycle against the expected-result queue.
// -----------------------------------------------------------------------------
module tb_divider_seq;
    import divider_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    divider_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t_acc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        d;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] got_q;
    logic [31:0] got_r;
    logic        got_d;
    logic        seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain 64-bit integer division with truncation toward zero.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint na;
        longint nb;
        if (b == 32'd0) begin
            e.q = DIV_ZERO_QUOTIENT; e.r = a; e.d = 1'b1; e.lat = 1;
        end else if (s && a == SIGNED_MIN && b == 32'hFFFF_FFFF) begin
            e.q = SIGNED_MIN; e.r = 32'd0; e.d = 1'b0; e.lat = 1;
        end else begin
            if (s) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            e.q = 32'(na / nb);
            e.r = 32'(na % nb);
            e.d = 1'b0;
            e.lat = 34;
        end
        return e;
    endfunction

    // Compare process: every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                chk("quotient", quotient, exp_q[0].q);
                chk("remainder", remainder, exp_q[0].r);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_q[0].d});
                chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                if (!seen) begin
                    chk("latency", cyc - t_acc + 1, exp_q[0].lat);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    got_q = quotient;
                    got_r = remainder;
                    got_d = div_by_zero;
                    seen  = 1'b0;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        seen = 1'b0;
    end

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic        lit;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ed;
        int          hold;
    } vec_t;

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        exp_q.push_back(model(a, b, s));
        x = a; y = b; is_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        t_acc    = cyc;
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input vec_t v);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        // Backpressure: offer junk operands that must be ignored.
        for (int h = 0; h < v.hold; h++) begin
            chk("in_ready_held", {31'd0, in_ready}, 32'd0);
            in_valid = 1'b1; x = 32'hDEAD_BEEF; y = 32'd3; is_signed = 1'b0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after_handoff", {31'd0, out_valid}, 32'd0);
        if (v.lit) begin
            chk("lit_quotient", got_q, v.eq);
            chk("lit_remainder", got_r, v.er);
            chk("lit_div_by_zero", {31'd0, got_d}, {31'd0, v.ed});
        end
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; is_signed = 1'b0;
        got_q = '0; got_r = '0; got_d = 1'b0; seen = 1'b0;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        //                x             y             s     lit   eq            er            ed    hold
        vecs.push_back('{32'd100,      32'd7,        1'b0, 1'b1, 32'd14,       32'd2,        1'b0, 0});
        vecs.push_back('{32'hFFFFFF9C, 32'd7,        1'b1, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 10});
        vecs.push_back('{32'd100,      32'hFFFFFFF9, 1'b1, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 0});
        vecs.push_back('{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 0});
        vecs.push_back('{32'h12345678, 32'd0,        1'b0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 3});
        vecs.push_back('{32'hFFFFFF9C, 32'd0,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 0});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 32'd0,        1'b0, 0});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0,        32'h80000000, 1'b0, 0});
        vecs.push_back('{32'h80000000, 32'd1,        1'b1, 1'b1, 32'h80000000, 32'd0,        1'b0, 0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd1,        32'd0,        1'b0, 0});
        vecs.push_back('{32'd7,        32'd100,      1'b0, 1'b1, 32'd0,        32'd7,        1'b0, 0});
        for (int i = 0; i < 4; i++) begin
            v.x = $urandom; v.y = $urandom_range(1, 100000); v.s = 1'(i);
            v.lit = 1'b0; v.eq = '0; v.er = '0; v.ed = 1'b0; v.hold = i;
            vecs.push_back(v);
        end

        foreach (vecs[i]) begin
            start_op(vecs[i].x, vecs[i].y, vecs[i].s);
            finish_op(vecs[i]);
        end

        // Reset during CALC cycle 15 abandons the operation.
        start_op(32'h12345678, 32'd3, 1'b0);
        while (cyc < t_acc + 15) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_quotient", quotient, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        v = '{32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, 0};
        start_op(v.x, v.y, v.s);
        finish_op(v);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_divider_seq
